// File: rtl/decrypt_seq_ctrl.sv
// Message-decrypt sequencer: recovers the LFSR tap and seed from the all-space preamble,
// then decrypts the block and writes the de-padded message to the bottom of data memory.
module decrypt_seq_ctrl #(
    parameter int unsigned SRC_BASE = 64,
    parameter int unsigned DST_BASE = 0,
    parameter int unsigned MSG_LEN  = 64,
    parameter int unsigned PRE_MIN  = 10
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       req,
    output logic       ack,
    output logic       err,
    output logic [6:0] out_len,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    localparam int unsigned LW = $clog2(PRE_MIN + 1);
    localparam int unsigned IW = $clog2(MSG_LEN);

    localparam logic [7:0]    SrcBase = 8'(SRC_BASE);
    localparam logic [7:0]    DstBase = 8'(DST_BASE);
    localparam logic [LW-1:0] PreEnd  = LW'(PRE_MIN);
    localparam logic [LW-1:0] PreLast = LW'(PRE_MIN - 1);
    localparam logic [IW-1:0] MsgLast = IW'(MSG_LEN - 1);
    localparam logic [3:0]    TapLast = 4'd8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSearch,
        StDecrypt,
        StDone
    } state_e;

    state_e        state_q;
    logic          armed_q;
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] k_q;
    logic [3:0]    tap_idx_q;
    logic [6:0]    s_q;
    logic [6:0]    tap_q;
    logic [6:0]    lfsr_q;
    logic [IW-1:0] idx_q;
    logic          phase_b_q;
    logic          seen_q;
    logic [6:0]    pre_buf_q [PRE_MIN];

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    function automatic logic [6:0] tap_at(input logic [3:0] i);
        logic [6:0] t;
        case (i)
            4'd0:    t = 7'h60;
            4'd1:    t = 7'h48;
            4'd2:    t = 7'h78;
            4'd3:    t = 7'h72;
            4'd4:    t = 7'h6A;
            4'd5:    t = 7'h69;
            4'd6:    t = 7'h5C;
            4'd7:    t = 7'h7E;
            4'd8:    t = 7'h7B;
            default: t = 7'h00;
        endcase
        return t;
    endfunction

    // Crypto bit 7 carries no key material.
    logic unused_rdata_msb;
    assign unused_rdata_msb = mem_rdata[7];

    logic [6:0] plain;
    logic [6:0] search_next;
    logic       write_en;
    logic       running;

    always_comb begin
        plain       = mem_rdata[6:0] ^ lfsr_q;
        search_next = lfsr_step(s_q, tap_at(tap_idx_q));
        running     = (state_q == StLoad) || (state_q == StSearch) || (state_q == StDecrypt);
        // Gated by req so an abort never lets a write land in its own cycle.
        write_en    = (state_q == StDecrypt) && phase_b_q && !req &&
                      (seen_q || (plain != 7'h00));
        mem_we      = write_en;
        mem_wdata   = write_en ? {1'b0, plain} : 8'h00;
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q   <= StIdle;
            armed_q   <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
            out_len   <= 7'd0;
            mem_addr  <= 8'h00;
            cnt_q     <= '0;
            k_q       <= '0;
            tap_idx_q <= 4'd0;
            s_q       <= 7'h00;
            tap_q     <= 7'h00;
            lfsr_q    <= 7'h00;
            idx_q     <= '0;
            phase_b_q <= 1'b0;
            seen_q    <= 1'b0;
            for (int i = 0; i < int'(PRE_MIN); i++) pre_buf_q[i] <= 7'h00;
        end else if (running && req) begin
            state_q <= StIdle;
            armed_q <= 1'b1;
            ack     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        armed_q  <= 1'b0;
                        err      <= 1'b0;
                        out_len  <= 7'd0;
                        cnt_q    <= '0;
                        mem_addr <= SrcBase;
                        state_q  <= StLoad;
                    end
                end
                StLoad: begin
                    // Read data lags the address by one cycle.
                    if (cnt_q != '0) pre_buf_q[cnt_q - LW'(1)] <= mem_rdata[6:0];
                    if (cnt_q == PreEnd) begin
                        if (pre_buf_q[0] == 7'h00) begin
                            err     <= 1'b1;
                            ack     <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            tap_idx_q <= 4'd0;
                            k_q       <= LW'(1);
                            s_q       <= pre_buf_q[0];
                            state_q   <= StSearch;
                        end
                    end else begin
                        cnt_q <= cnt_q + LW'(1);
                        if (cnt_q != PreLast) mem_addr <= SrcBase + 8'(cnt_q) + 8'd1;
                    end
                end
                StSearch: begin
                    if (search_next == pre_buf_q[k_q]) begin
                        if (k_q == PreLast) begin
                            tap_q     <= tap_at(tap_idx_q);
                            lfsr_q    <= pre_buf_q[0];
                            idx_q     <= '0;
                            phase_b_q <= 1'b0;
                            seen_q    <= 1'b0;
                            mem_addr  <= SrcBase;
                            state_q   <= StDecrypt;
                        end else begin
                            k_q <= k_q + LW'(1);
                            s_q <= search_next;
                        end
                    end else if (tap_idx_q == TapLast) begin
                        err     <= 1'b1;
                        ack     <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        tap_idx_q <= tap_idx_q + 4'd1;
                        k_q       <= LW'(1);
                        s_q       <= pre_buf_q[0];
                    end
                end
                StDecrypt: begin
                    if (!phase_b_q) begin
                        phase_b_q <= 1'b1;
                        mem_addr  <= DstBase + 8'(out_len);
                    end else begin
                        if (write_en) begin
                            out_len <= out_len + 7'd1;
                            seen_q  <= 1'b1;
                        end
                        lfsr_q    <= lfsr_step(lfsr_q, tap_q);
                        phase_b_q <= 1'b0;
                        if (idx_q == MsgLast) begin
                            ack     <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q    <= idx_q + IW'(1);
                            mem_addr <= SrcBase + 8'(idx_q) + 8'd1;
                        end
                    end
                end
                StDone: begin
                    if (req) begin
                        ack     <= 1'b0;
                        armed_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_decrypt_seq_ctrl.sv
// Scoreboard bench for decrypt_seq_ctrl: stimulus pushes expected writes and completion
// results; a negedge monitor pops and compares whenever the DUT writes or raises ack.
module tb_decrypt_seq_ctrl;

    localparam int SRC = 64;

    logic       clk = 1'b0;
    logic       init_n;
    logic       req;
    logic       ack;
    logic       err;
    logic [6:0] out_len;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    decrypt_seq_ctrl dut (
        .clk      (clk),
        .init_n   (init_n),
        .req      (req),
        .ack      (ack),
        .err      (err),
        .out_len  (out_len),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [15:0] wr_q [$];
    logic [7:0]  res_q [$];
    int   done_cnt = 0;
    int   wr_cnt   = 0;
    logic ack_d    = 1'b0;

    // Monitor
    always @(negedge clk) begin
        logic [15:0] w;
        logic [7:0]  r;
        if (mem_we) begin
            wr_cnt++;
            if (wr_q.size() == 0) begin
                check("spurious_write", int'(mem_we), 0);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", int'(mem_addr), int'(w[15:8]));
                check("wr_data", int'(mem_wdata), int'(w[7:0]));
            end
        end
        if (ack && !ack_d) begin
            done_cnt++;
            if (res_q.size() == 0) begin
                check("spurious_ack", int'(ack), 0);
            end else begin
                r = res_q.pop_front();
                check("done_err", int'(err), int'(r[7]));
                check("done_len", int'(out_len), int'(r[6:0]));
                check("writes_left", wr_q.size(), 0);
            end
        end
        ack_d = ack;
    end

    logic [6:0] plain  [64];
    logic [7:0] cipher [64];
    int         exp_len;
    logic [6:0] taps [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

    task automatic build(input string msg, input int pre);
        byte ch;
        for (int j = 0; j < 64; j++) begin
            ch = " ";
            if (j >= pre && (j - pre) < msg.len()) ch = msg[j - pre];
            plain[j] = 7'(ch - 8'h20);
        end
    endtask

    task automatic encrypt(input logic [6:0] tap, input logic [6:0] init, input bit msb);
        logic [6:0] s = init;
        for (int j = 0; j < 64; j++) begin
            cipher[j] = {msb, plain[j] ^ s};
            s = {s[5:0], ^(s & tap)};
        end
    endtask

    task automatic load_mem();
        for (int j = 0; j < 64; j++) begin
            mem[SRC + j] = cipher[j];
            mem[j]       = 8'hEE;
        end
    endtask

    task automatic push_expect(input bit exp_err);
        int first = 64;
        if (!exp_err) begin
            for (int j = 63; j >= 0; j--) if (plain[j] != 7'h00) first = j;
            for (int j = first; j < 64; j++) wr_q.push_back({8'(j - first), 1'b0, plain[j]});
        end
        exp_len = 64 - first;
        res_q.push_back({exp_err, 7'(exp_len)});
    endtask

    task automatic start_run();
        @(posedge clk); #2 req = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2 req = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int c = 0; c < 600 && done_cnt < target; c++) @(posedge clk);
        check("done_reached", done_cnt, target);
        @(posedge clk); #2;
    endtask

    task automatic wait_writes(input int n);
        int t = wr_cnt + n;
        for (int c = 0; c < 600 && wr_cnt < t; c++) @(negedge clk);
        check("writes_reached", int'(wr_cnt >= t), 1);
        @(posedge clk); #2;
    endtask

    task automatic check_tail(input string name);
        int n = 0;
        for (int j = exp_len; j < 64; j++) if (mem[j] != 8'hEE) n++;
        check(name, n, 0);
    endtask

    task automatic run_case(input bit exp_err, input string name);
        int tgt = done_cnt + 1;
        load_mem();
        push_expect(exp_err);
        start_run();
        wait_done(tgt);
        check_tail(name);
    endtask

    initial begin
        int w0;
        int tgt;
        for (int j = 0; j < 256; j++) mem[j] = 8'h00;
        init_n = 1'b0;
        req    = 1'b0;
        #1;
        check("rst_ack", int'(ack), 0);
        check("rst_err", int'(err), 0);
        check("rst_len", int'(out_len), 0);
        check("rst_we", int'(mem_we), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_wdata", int'(mem_wdata), 0);
        #20 init_n = 1'b1;

        // Digits and letters, tap 0x7E, seed 0x36
        build("  01234546789abcdefghijklmnopqrstuvwxyz. ", 10);
        encrypt(7'h7E, 7'h36, 1'b0);
        run_case(1'b0, "t1_tail");
        check("t1_len", int'(out_len), 52);
        check("t1_dm0", int'(mem[0]), 8'h10);
        check("t1_dm51", int'(mem[51]), 8'h00);
        check("t1_dm52", int'(mem[52]), 8'hEE);

        // Longer preamble, tap 0x60, seed 0x01
        build("Mr. Watson, come here. I want to see you.", 15);
        encrypt(7'h60, 7'h01, 1'b0);
        w0 = wr_cnt;
        run_case(1'b0, "t2_tail");
        check("t2_len", int'(out_len), 49);
        check("t2_dm0", int'(mem[0]), 8'h2D);
        check("t2_wr_count", wr_cnt - w0, 49);

        // All-space block: nothing written
        build("", 10);
        encrypt(7'h5C, 7'h7F, 1'b0);
        w0 = wr_cnt;
        run_case(1'b0, "t3_tail");
        check("t3_err", int'(err), 0);
        check("t3_wr_count", wr_cnt - w0, 0);

        // Zero seed: error out of LOAD
        for (int j = 0; j < 64; j++) cipher[j] = 8'h00;
        w0 = wr_cnt;
        run_case(1'b1, "t4_tail");
        check("t4_err", int'(err), 1);
        check("t4_wr_count", wr_cnt - w0, 0);

        // Pattern matching no tap: error after full search
        for (int j = 0; j < 64; j++) cipher[j] = 8'h55;
        w0 = wr_cnt;
        run_case(1'b1, "t5_tail");
        check("t5_err", int'(err), 1);
        check("t5_len", int'(out_len), 0);
        check("t5_wr_count", wr_cnt - w0, 0);

        // Every tap index with seed 0x36
        build("  01234546789abcdefghijklmnopqrstuvwxyz. ", 10);
        for (int t = 0; t < 9; t++) begin
            encrypt(taps[t], 7'h36, 1'b0);
            run_case(1'b0, "tap_sweep_tail");
        end

        // Crypto bit 7 ignored
        encrypt(7'h7E, 7'h36, 1'b1);
        run_case(1'b0, "msb_tail");
        check("msb_dm0", int'(mem[0]), 8'h10);

        // Abort mid-DECRYPT, then rerun from armed state
        encrypt(7'h7E, 7'h36, 1'b0);
        load_mem();
        push_expect(1'b0);
        start_run();
        wait_writes(5);
        req = 1'b1;
        wr_q.delete();
        res_q.delete();
        w0 = wr_cnt;
        repeat (20) @(posedge clk);
        #2;
        check("abort_ack", int'(ack), 0);
        check("abort_no_writes", wr_cnt - w0, 0);
        push_expect(1'b0);
        tgt = done_cnt + 1;
        req = 1'b0;
        wait_done(tgt);
        check("rerun_len", int'(out_len), 52);
        check_tail("rerun_tail");

        // Asynchronous reset mid-DECRYPT
        load_mem();
        push_expect(1'b0);
        start_run();
        wait_writes(3);
        wr_q.delete();
        res_q.delete();
        init_n = 1'b0;
        #1;
        check("arst_ack", int'(ack), 0);
        check("arst_err", int'(err), 0);
        check("arst_len", int'(out_len), 0);
        check("arst_we", int'(mem_we), 0);
        check("arst_addr", int'(mem_addr), 0);
        check("arst_wdata", int'(mem_wdata), 0);
        w0 = wr_cnt;
        repeat (3) @(posedge clk);
        #2 init_n = 1'b1;
        repeat (10) @(posedge clk);
        check("arst_idle_no_writes", wr_cnt - w0, 0);
        run_case(1'b0, "post_rst_tail");
        check("post_rst_len", int'(out_len), 52);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
